sample_packer: RTL
==================

Name: sample_packer

Overview:
- Downstream neighbour of the RLE encoder in the Logic Sniffer core.
- Takes the encoder's per-sample output stream, where each sample is 1, 2, 3 or 4 bytes wide depending on the enabled channel groups (the same `mode` encoding the encoder uses), and packs the bytes densely into 32-bit words for the sample memory. This removes the wasted upper bytes when fewer than four groups are enabled.
- Provides an end-of-capture flush that emits a final partial word with a valid-byte count.

Parameters:
- DW, 32, width of input sample bus and output word; fixed at 32.
- CW, 16, width of the emitted-word counter.

Ports:
- clock  input  1  sample-domain core clock
- reset_n  input  1  synchronous, active-low reset
- mode  input  2  bytes per sample minus 1 (0=8b, 1=16b, 2=24b, 3=32b); latched on arm
- arm  input  1  one-cycle pulse: clear packer, latch mode, enter RUN
- flush  input  1  one-cycle pulse: end of capture, drain residue
- validIn  input  1  sample strobe from RLE encoder
- dataIn  input  32  sample; only bytes [mode:0] used, upper bytes ignored
- validOut  output  1  dataOut holds a word this cycle
- dataOut  output  32  packed word, earliest byte in [7:0]
- bytesOut  output  3  valid bytes in dataOut (4 for full words, 1..3 for final partial)
- lastOut  output  1  marks final output of a capture
- wordCount  output  CW  words emitted since arm; saturates at all-ones

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, fill=0, accumulator=0.
  - validOut=0, dataOut=0, bytesOut=0, lastOut=0, wordCount=0.
  - Reset mid-capture discards the residue with no output.
- States:
  - IDLE: validIn and flush ignored; arm -> RUN.
  - RUN: packing; flush -> IDLE or DRAIN.
  - DRAIN: emit second word of a flush, then -> IDLE.
- Arm:
  - In any state: clears accumulator, fill and wordCount, and latches mode (as mbytes = mode+1).
  - arm in RUN or DRAIN aborts with no output; arm has priority over validIn and flush in the same cycle.
  - mode changes outside arm have no effect.
- Accumulator:
  - 56 bits (7 bytes); fill is 0..7 bytes held.
  - On validIn in RUN, the low mbytes of dataIn are appended at byte position fill (LSB first): total = fill + mbytes.
  - If total >= 4:
    - next cycle validOut=1, dataOut=accum bytes[3:0], bytesOut=4;
    - accumulator shifts down 4 bytes; fill = total - 4.
  - Otherwise fill = total, no output.
  - At most one word results per validIn. With fill <= 3 and mbytes <= 4, total is at most 7.
- Latency: one clock from the completing validIn to validOut. Back-to-back validIn is supported every cycle at any mode; no backpressure.
- Flush in RUN (validIn in the same cycle is appended first, giving total):
  - total = 0: next cycle lastOut=1, validOut=0, bytesOut=0; -> IDLE.
  - 1 <= total <= 4: next cycle validOut=1, lastOut=1, bytesOut=total, dataOut = residue zero-padded above; -> IDLE.
  - total > 4:
    - next cycle: full word, bytesOut=4, lastOut=0; -> DRAIN.
    - following cycle: remainder, bytesOut = total-4, lastOut=1, zero-padded; -> IDLE.
  - validIn during DRAIN is ignored.
- Output pulses: validOut and lastOut are single-cycle pulses. When validOut=0, dataOut and bytesOut are held at 0.
- wordCount increments once per validOut=1 (partial words included) and stops at 2^CW-1.

Test Plan:
- arm with mode=0; validIn 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> one cycle after the 4th: validOut=1, dataOut=0x44332211, bytesOut=4, wordCount=1.
- arm with mode=2; samples 0xAABBCC then 0xDDEEFF -> single word 0xFFAABBCC after the 2nd; then flush -> dataOut=0x0000DDEE, bytesOut=2, lastOut=1, state IDLE.
- mode=2, one sample 0xAABBCC held, then flush with simultaneous validIn 0x123456 -> cycle 1: 0x56AABBCC, bytesOut=4, lastOut=0; cycle 2: 0x00001234, bytesOut=2, lastOut=1.
- mode=3 with 8 back-to-back samples 0x01020304+i -> each echoed one cycle later with bytesOut=4, wordCount=8; flush -> lastOut=1, validOut=0.
- mode=1, one sample held (fill=2), then reset_n=0 for one cycle -> all outputs 0, no word; subsequent validIn 0x1234 ignored (IDLE) until arm.
- In IDLE, validIn and flush pulses -> no outputs; arm during RUN with fill=3 -> residue discarded, wordCount=0, no validOut.

Source files
------------

// File: rtl/sample_packer_if.sv
// Bus bundle between the RLE encoder side, the packer and the sample memory side.
// The master drives control and samples; the slave (the packer) returns packed words and debug state.
interface sample_packer_if #(
    parameter int DW = 32,
    parameter int CW = 16
);
    logic [1:0]    mode;
    logic          arm;
    logic          flush;
    logic          validIn;
    logic [DW-1:0] dataIn;
    logic          validOut;
    logic [DW-1:0] dataOut;
    logic [2:0]    bytesOut;
    logic          lastOut;
    logic [CW-1:0] wordCount;
    logic [1:0]    dbg_state;

    modport master (
        output mode, arm, flush, validIn, dataIn,
        input  validOut, dataOut, bytesOut, lastOut, wordCount, dbg_state
    );

    modport slave (
        input  mode, arm, flush, validIn, dataIn,
        output validOut, dataOut, bytesOut, lastOut, wordCount, dbg_state
    );
endinterface

// File: rtl/sample_packer.sv
// Packs 1..4-byte samples densely into 32-bit words, earliest byte in [7:0],
// with an end-of-capture flush that emits a final partial word and byte count.
module sample_packer #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    sample_packer_if.slave bus
);

    // Handshake: validIn is a one-cycle strobe with no backpressure; every
    // validOut is a single-cycle pulse that the sink must accept unconditionally.
    localparam int AW = 56;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mbytes_q, mbytes_d;
    logic [AW-1:0] accum_q, accum_d;
    logic [2:0]    fill_q, fill_d;
    logic          valid_out_q, valid_out_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic [2:0]    bytes_out_q, bytes_out_d;
    logic          last_out_q, last_out_d;
    logic [CW-1:0] word_count_q, word_count_d;

    logic [DW-1:0] sample_mask;
    logic [DW-1:0] sample_masked;
    logic [AW-1:0] merged;
    logic [3:0]    total;

    always_comb begin
        sample_mask = '1;
        case (mbytes_q)
            3'd1:    sample_mask = 32'h0000_00FF;
            3'd2:    sample_mask = 32'h0000_FFFF;
            3'd3:    sample_mask = 32'h00FF_FFFF;
            default: sample_mask = 32'hFFFF_FFFF;
        endcase
        sample_masked = bus.dataIn & sample_mask;
    end

    always_comb begin
        state_d      = state_q;
        mbytes_d     = mbytes_q;
        accum_d      = accum_q;
        fill_d       = fill_q;
        valid_out_d  = 1'b0;
        data_out_d   = '0;
        bytes_out_d  = '0;
        last_out_d   = 1'b0;
        word_count_d = word_count_q;

        // Bytes above fill are kept zero, so a plain OR appends the new sample.
        merged = accum_q;
        total  = {1'b0, fill_q};
        if (state_q == RUN && bus.validIn) begin
            merged = accum_q | (AW'(sample_masked) << {fill_q, 3'b000});
            total  = {1'b0, fill_q} + {1'b0, mbytes_q};
        end

        if (bus.arm) begin
            state_d  = RUN;
            mbytes_d = {1'b0, bus.mode} + 3'd1;
            accum_d  = '0;
            fill_d   = '0;
            word_count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                RUN: begin
                    if (bus.flush) begin
                        if (total > 4'd4) begin
                            valid_out_d = 1'b1;
                            data_out_d  = merged[DW-1:0];
                            bytes_out_d = 3'd4;
                            accum_d     = merged >> DW;
                            fill_d      = 3'(total - 4'd4);
                            state_d     = DRAIN;
                        end else begin
                            valid_out_d = (total != 4'd0);
                            data_out_d  = merged[DW-1:0];
                            bytes_out_d = total[2:0];
                            last_out_d  = 1'b1;
                            accum_d     = '0;
                            fill_d      = '0;
                            state_d     = IDLE;
                        end
                    end else if (total >= 4'd4) begin
                        valid_out_d = 1'b1;
                        data_out_d  = merged[DW-1:0];
                        bytes_out_d = 3'd4;
                        accum_d     = merged >> DW;
                        fill_d      = 3'(total - 4'd4);
                    end else begin
                        accum_d = merged;
                        fill_d  = total[2:0];
                    end
                end
                DRAIN: begin
                    valid_out_d = 1'b1;
                    data_out_d  = accum_q[DW-1:0];
                    bytes_out_d = fill_q;
                    last_out_d  = 1'b1;
                    accum_d     = '0;
                    fill_d      = '0;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    accum_d = '0;
                    fill_d  = '0;
                end
            endcase

            if (valid_out_d && word_count_q != '1) begin
                word_count_d = word_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mbytes_q     <= 3'd4;
            accum_q      <= '0;
            fill_q       <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            bytes_out_q  <= '0;
            last_out_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mbytes_q     <= mbytes_d;
            accum_q      <= accum_d;
            fill_q       <= fill_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            bytes_out_q  <= bytes_out_d;
            last_out_q   <= last_out_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.validOut  = valid_out_q;
    assign bus.dataOut   = data_out_q;
    assign bus.bytesOut  = bytes_out_q;
    assign bus.lastOut   = last_out_q;
    assign bus.wordCount = word_count_q;
    assign bus.dbg_state = state_q;

endmodule
